// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multiplier: default geometry and the
// per-stage register bundle passed between pipeline stages.
package mult_pkg;

  localparam int MULT_WIDTH  = 64;
  localparam int MULT_STAGES = 8;
  localparam int MULT_BPS    = MULT_WIDTH / MULT_STAGES;

  // One pipeline stage worth of state: the partial product accumulated so
  // far, the multiplicand pre-shifted to the weight of the next digit, and
  // the multiplier with already-retired digits shifted out.
  typedef struct packed {
    logic                  valid;
    logic [MULT_WIDTH-1:0] pp;
    logic [MULT_WIDTH-1:0] mc;
    logic [MULT_WIDTH-1:0] mp;
  } mult_stage_t;

endpackage : mult_pkg

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: retires the low BPS bits of the multiplier
// into the partial product, then registers the updated bundle.
import mult_pkg::*;

module mult_stage #(
  parameter int WIDTH = MULT_WIDTH,
  parameter int BPS   = MULT_BPS
) (
  input  logic        clock,
  input  logic        reset,
  input  mult_stage_t i_stage,
  output mult_stage_t o_stage
);

  logic [WIDTH-1:0] w_digit;
  logic [WIDTH-1:0] w_ppNext;
  logic [WIDTH-1:0] w_mcNext;
  logic [WIDTH-1:0] w_mpNext;
  mult_stage_t      r_stage;

  // Zero-extend the retiring multiplier digit so the product is taken at full
  // width and truncated modulo 2^WIDTH like every other value in the pipe.
  assign w_digit  = {{(WIDTH-BPS){1'b0}}, i_stage.mp[BPS-1:0]};
  assign w_ppNext = i_stage.pp + i_stage.mc * w_digit;
  assign w_mcNext = i_stage.mc << BPS;
  assign w_mpNext = i_stage.mp >> BPS;

  // The stage loads every edge with no stall; valid simply travels with the
  // data so bubbles carry harmless garbage that nobody consumes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage.valid <= i_stage.valid;
      r_stage.pp    <= w_ppNext;
      r_stage.mc    <= w_mcNext;
      r_stage.mp    <= w_mpNext;
    end
  end

  assign o_stage = r_stage;

endmodule : mult_stage

// File: rtl/pipe_mult.sv
// Fully pipelined unsigned multiplier. A chain of STAGES identical stages each
// retires WIDTH/STAGES multiplier bits; one operand pair may enter per cycle
// and results leave in issue order STAGES cycles later.
import mult_pkg::*;

module pipe_mult #(
  parameter int WIDTH  = MULT_WIDTH,
  parameter int STAGES = MULT_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic             start,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  // STAGES must divide WIDTH; each stage handles exactly this many bits.
  localparam int BPS = WIDTH / STAGES;

  // w_chain[0] is the port-side input; w_chain[k] is stage k's register.
  mult_stage_t w_chain [0:STAGES];

  assign w_chain[0].valid = start;
  assign w_chain[0].pp    = '0;
  assign w_chain[0].mc    = mcand;
  assign w_chain[0].mp    = mplier;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    mult_stage #(
      .WIDTH (WIDTH),
      .BPS   (BPS)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .i_stage (w_chain[k-1]),
      .o_stage (w_chain[k])
    );
  end

  // The last stage has retired every multiplier digit, so its partial
  // product is the final (truncated) result.
  assign product = w_chain[STAGES].pp;
  assign done    = w_chain[STAGES].valid;

endmodule : pipe_mult

// File: tb/tb_pipe_mult.sv
// Self-checking bench for pipe_mult: a queue-based reference model predicts
// every done pulse and product, and directed scenarios pin literal results.
module tb_pipe_mult;

  localparam int W = 64;
  localparam int S = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         start;
  logic [W-1:0] product;
  logic         done;

  int assertCount;
  int failCount;
  int edgeCount;

  typedef struct {
    int           due;
    logic [W-1:0] value;
  } expect_t;

  expect_t pending[$];

  pipe_mult #(.WIDTH(W), .STAGES(S)) dut (
    .clock   (clock),
    .reset   (reset),
    .mcand   (mcand),
    .mplier  (mplier),
    .start   (start),
    .product (product),
    .done    (done)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Shared comparison: counts every check and reports any disagreement.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] required);
    assertCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at edge %0d",
               name, actual, required, edgeCount);
    end
  endtask

  // Model: every accepted start owes exactly one result, due after the
  // (STAGES-1)th edge following its own; reset forgets everything owed.
  always @(posedge clock) begin
    edgeCount++;
    if (reset) begin
      pending.delete();
    end else if (start) begin
      expect_t e;
      e.due   = edgeCount + S - 1;
      e.value = mcand * mplier;
      pending.push_back(e);
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clock) begin
    logic expDone;
    expDone = (pending.size() > 0) && (pending[0].due == edgeCount);
    checkOutput("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, expDone});
    if (expDone) begin
      checkOutput("product", product, pending[0].value);
      void'(pending.pop_front());
    end else if ((pending.size() > 0) && (pending[0].due < edgeCount)) begin
      checkOutput("overdue", {{(W-1){1'b0}}, done}, {W{1'b1}});
      void'(pending.pop_front());
    end
  end

  // Drive one cycle of start with the given operands, starting at a negedge.
  task automatic applyStimulus(input logic [W-1:0] mc, input logic [W-1:0] mp);
    start  = 1'b1;
    mcand  = mc;
    mplier = mp;
    @(negedge clock);
    start  = 1'b0;
  endtask

  // Launch one multiply and check the literal result STAGES edges later.
  task automatic launchAndPin(input string name, input logic [W-1:0] mc,
                              input logic [W-1:0] mp, input logic [W-1:0] lit);
    applyStimulus(mc, mp);
    repeat (S - 2) @(negedge clock);
    checkOutput({name, "_early"}, {{(W-1){1'b0}}, done}, '0);
    @(negedge clock);
    checkOutput({name, "_done"}, {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
    checkOutput({name, "_product"}, product, lit);
    @(negedge clock);
    checkOutput({name, "_pulse"}, {{(W-1){1'b0}}, done}, '0);
  endtask

  initial begin
    logic [W-1:0] bbMc  [4];
    logic [W-1:0] bbMp  [4];
    logic [W-1:0] bbLit [4];
    int           idleDone;

    assertCount = 0;
    failCount   = 0;
    edgeCount   = 0;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;

    // Reset for two edges; outputs must read zero.
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_done", {{(W-1){1'b0}}, done}, '0);
    checkOutput("reset_product", product, '0);
    reset = 1'b0;
    @(negedge clock);

    // Basic latency, wide operands, overflow.
    launchAndPin("basic", 64'd3, 64'd3, 64'd9);
    launchAndPin("wide", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    launchAndPin("overflow", 64'h8000_0000_0000_0000, 64'd2, 64'd0);
    launchAndPin("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                 64'h1234_5678_9ABC_DEF0 * 64'h0FED_CBA9_8765_4321);

    // Back-to-back: four consecutive starts give four consecutive dones.
    bbMc  = '{64'h1, 64'h2, 64'h10, 64'hFFFF};
    bbMp  = '{64'h1, 64'h3, 64'h10, 64'h10001};
    bbLit = '{64'h1, 64'h6, 64'h100, 64'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      start  = 1'b1;
      mcand  = bbMc[i];
      mplier = bbMp[i];
      @(negedge clock);
    end
    start = 1'b0;
    repeat (S - 4) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b_done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
      checkOutput("b2b_product", product, bbLit[i]);
      @(negedge clock);
    end
    checkOutput("b2b_after", {{(W-1){1'b0}}, done}, '0);
    repeat (2) @(negedge clock);

    // Reset mid-flight: (5,7) is dropped, (6,6) right after reset survives.
    applyStimulus(64'd5, 64'd7);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset  = 1'b0;
    start  = 1'b1;
    mcand  = 64'd6;
    mplier = 64'd6;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      checkOutput("flush_quiet", {{(W-1){1'b0}}, done}, '0);
      @(negedge clock);
    end
    checkOutput("flush_done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
    checkOutput("flush_product", product, 64'd36);
    @(negedge clock);

    // Idle noise: operands wiggle with start low; nothing may complete.
    idleDone = 0;
    for (int i = 0; i < 20; i++) begin
      mcand  = {$urandom, $urandom};
      mplier = {$urandom, $urandom};
      @(negedge clock);
      if (done) idleDone++;
    end
    checkOutput("idle_dones", W'(idleDone), '0);

    // Let the pipe drain so the model can confirm nothing is left owed.
    repeat (S + 2) @(negedge clock);
    checkOutput("model_drained", W'(pending.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule : tb_pipe_mult
